// File: rtl/hs_buffer_fifo.sv
// hs_buffer_fifo: elastic FIFO between a busy-handshake producer and sink.
// Define HS_BUFFER_STATS_EN to add saturating stat_xfer/stat_stall counters.
module hs_buffer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_en,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_busy,
  output logic             out_en,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_busy,
  output logic [AW:0]      level,
  output logic             ovf_err
`ifdef HS_BUFFER_STATS_EN
  ,
  output logic [31:0]      stat_xfer,
  output logic [31:0]      stat_stall
`endif
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic push, pop;
  assign in_busy = cnt == (AW+1)'(DEPTH);
  assign out_en = cnt != '0 && !out_busy;
  assign out_data = cnt != '0 ? mem[rp] : '0;
  assign push = in_en && !in_busy;
  assign pop = out_en;
  assign level = cnt;
  always_ff @(posedge clk)
    if (push && rst_n) mem[wp] <= in_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (in_en && in_busy) ovf_err <= 1'b1;
    end
  end
`ifdef HS_BUFFER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_xfer <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && stat_xfer != '1) stat_xfer <= stat_xfer + 1'b1;
      if (cnt != '0 && out_busy && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hs_buffer_fifo.sv
// tb_hs_buffer_fifo: queue-model checker plus directed literal checks for hs_buffer_fifo.
module tb_hs_buffer_fifo;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, in_en = 0, out_busy = 0;
  logic [31:0] in_data = 0;
  logic in_busy, out_en, ovf_err;
  logic [31:0] out_data;
  logic [2:0] level;
`ifdef HS_BUFFER_STATS_EN
  logic [31:0] stat_xfer, stat_stall;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q[$];
  bit valid = 0, m_ovf = 0, m_full, m_pop;
  longint m_xfer = 0, m_stall = 0;

  hs_buffer_fifo #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_data(in_data), .in_busy(in_busy),
    .out_en(out_en), .out_data(out_data), .out_busy(out_busy), .level(level), .ovf_err(ovf_err)
`ifdef HS_BUFFER_STATS_EN
    , .stat_xfer(stat_xfer), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: FIFO as a plain queue, updated from the inputs seen at each edge
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ovf = 0;
      m_xfer = 0;
      m_stall = 0;
      valid = 1;
    end else if (valid) begin
      m_full = q.size() == DEPTH;
      m_pop = q.size() != 0 && !out_busy;
      if (q.size() != 0 && out_busy) m_stall++;
      if (m_pop) begin
        void'(q.pop_front());
        m_xfer++;
      end
      if (in_en && !m_full) q.push_back(in_data);
      if (in_en && m_full) m_ovf = 1;
    end
  end

  always @(negedge clk) if (valid) begin
    chk("in_busy", in_busy, q.size() == DEPTH);
    chk("out_en", out_en, q.size() != 0 && !out_busy);
    chk("out_data", out_data, q.size() != 0 ? q[0] : 0);
    chk("level", level, q.size());
    chk("ovf_err", ovf_err, m_ovf);
`ifdef HS_BUFFER_STATS_EN
    chk("stat_xfer", stat_xfer, m_xfer);
    chk("stat_stall", stat_stall, m_stall);
`endif
  end

  task automatic drive(input logic e, input logic [31:0] d, input logic b);
    in_en = e;
    in_data = d;
    out_busy = b;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent;
    logic e;
    tick;
    tick;
    rst_n = 1;
    drive(1, 32'h11, 0);
    chk("rst_level", level, 0);
    chk("rst_out_en", out_en, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_busy", in_busy, 0);
    tick;
    drive(1, 32'h22, 0);
    chk("t1_w0", out_data, 32'h11);
    chk("t1_en0", out_en, 1);
    tick;
    drive(1, 32'h33, 0);
    chk("t1_w1", out_data, 32'h22);
    chk("t1_lvl", level, 1);
    tick;
    drive(0, 0, 0);
    chk("t1_w2", out_data, 32'h33);
    tick;
    drive(0, 0, 0);
    chk("t1_empty", out_en, 0);
    for (int i = 1; i <= 4; i++) begin
      drive(1, i, 1);
      tick;
    end
    drive(1, 32'h5, 1);
    chk("t2_full", in_busy, 1);
    chk("t2_lvl4", level, 4);
    tick;
    drive(0, 0, 1);
    chk("t2_ovf", ovf_err, 1);
    chk("t2_lvl_keep", level, 4);
    tick;
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0);
      chk("t2_order", out_data, i);
      tick;
    end
    drive(0, 0, 0);
    chk("t2_drained", level, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hB0 + i, 1);
      tick;
    end
    drive(1, 32'hAA, 0);
    chk("t3_busy", in_busy, 1);
    chk("t3_pop", out_data, 32'hB0);
    tick;
    drive(0, 0, 1);
    chk("t3_lvl3", level, 3);
    chk("t3_head", out_data, 32'hB1);
    tick;
    rst_n = 0;
    drive(0, 0, 0);
    tick;
    rst_n = 1;
    drive(0, 0, 0);
    chk("t4_ovf_clr", ovf_err, 0);
    sent = 0;
    for (int k = 0; sent < 30 && k < 500; k++) begin
      e = $urandom_range(1, 0) == 1 && !in_busy;
      drive(e, $urandom, $urandom_range(3, 0) == 0);
      if (e) sent++;
      tick;
    end
    chk("t4_sent", sent, 30);
    for (int k = 0; k < 20 && level != 0; k++) begin
      drive(0, 0, 0);
      tick;
    end
    drive(0, 0, 0);
    chk("t4_final_lvl", level, 0);
    chk("t4_ovf", ovf_err, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hC0 + i, 1);
      tick;
    end
    drive(1, 32'h77, 1);
    chk("t5_lvl3", level, 3);
    rst_n = 0;
    tick;
    rst_n = 1;
    drive(0, 0, 0);
    chk("t5_lvl0", level, 0);
    chk("t5_out_en", out_en, 0);
    tick;
    drive(0, 0, 0);
    chk("t5_no_stale", out_en, 0);
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/hs_buffer_fifo.md
# hs_buffer_fifo

Elastic buffer stage that sits directly downstream of the handshake core and consumes its `slave_en`/`slave_data` stream, absorbing bursts while the final sink is busy. Words are stored in a power-of-two FIFO and replayed to the sink under a busy-based handshake, in arrival order, with no loss and no duplication. The upstream `slave_busy` input of the handshake core is driven from this block's `in_busy`.

## Interface
Parameters:
- `WIDTH`, 32, data word width in bits
- `DEPTH`, 4, number of storage entries; power of two, ≥ 2
- `AW`, `$clog2(DEPTH)`, pointer width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_en`  in  1  producer pushes `in_data` this cycle
- `in_data`  in  WIDTH  pushed word
- `in_busy`  out  1  block cannot accept a push this cycle
- `out_en`  out  1  `out_data` is delivered to the sink this cycle
- `out_data`  out  WIDTH  head-of-FIFO word
- `out_busy`  in  1  sink refuses delivery this cycle
- `level`  out  AW+1  current occupancy, 0..DEPTH
- `ovf_err`  out  1  sticky: a push was attempted while `in_busy` was high

## Operation
- Storage: `DEPTH` × `WIDTH` register array; write pointer `wp` and read pointer `rp` of width AW, plus count register `cnt` of width AW+1.
- Pointers wrap modulo `DEPTH` (natural AW-bit overflow); `cnt` never wraps.
- `in_busy = (cnt == DEPTH)`, decoded from registered state only; no combinational path from any input.
- Push accepted = `in_en && !in_busy`. The word is written at `mem[wp]`, then `wp <= wp+1`.
- `out_en = (cnt != 0) && !out_busy`, combinational from `out_busy`. `out_data = mem[rp]` whenever `cnt != 0`; it is 0 when `cnt == 0`.
- Pop = `out_en`, then `rp <= rp+1`.
- `cnt` update: push only → +1; pop only → −1; both or neither → unchanged.
- No fall-through: a word pushed in cycle N is visible to the sink no earlier than cycle N+1.
- Full with pop in the same cycle: `in_busy` stays high for that cycle and any `in_en` is rejected; `in_busy` drops the following cycle.
- Empty with push: no pop that cycle; the next cycle `out_en` asserts if `out_busy == 0`.
- `in_en` while `in_busy`: the data is dropped, no state changes except `ovf_err <= 1`. `ovf_err` clears only on reset.
- `level = cnt`.

## Timing
- Reset (`rst_n == 0` at a rising edge): `wp`, `rp`, `cnt`, `ovf_err` all go to 0. After reset `in_busy = 0`, `out_en = 0`, `out_data = 0`, `level = 0`. Memory contents are not cleared.
- Reset mid-operation discards all stored words. It takes priority over a push or pop in the same cycle.
- Minimum latency from `in_en` to `out_en` is 1 cycle.
- Sustained throughput is 1 word/cycle when `out_busy` is low.
- `in_busy` responds 1 cycle after the push that fills the FIFO.
- `out_en` responds in the same cycle as `out_busy` changes.

## Configuration
- `HS_BUFFER_STATS_EN` defined adds two outputs:
  - `stat_xfer` (32 bit): counts pops.
  - `stat_stall` (32 bit): counts cycles with `cnt != 0 && out_busy`.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- `HS_BUFFER_STATS_EN` undefined: these ports and their counters do not exist, and core behaviour is identical.

## Test plan
- Reset, then push 32'h11, 32'h22, 32'h33 on consecutive cycles with `out_busy = 0` → `out_en` pulses in cycles 1..3 after the first push, carrying 32'h11, 32'h22, 32'h33; `level` peaks at 1.
- Hold `out_busy = 1`, push 4 words 1..4 → `level = 4` and `in_busy = 1`; a fifth `in_en` with 32'h5 is dropped and `ovf_err = 1`. Release `out_busy` → 1,2,3,4 are delivered in order.
- Full FIFO, `out_busy = 0` with `in_en` (32'hAA) in the same cycle → pop of the head, 32'hAA rejected, `ovf_err = 1`, `level = 3` next cycle.
- 30 random words with random `in_en`/`out_busy` (25 % busy), producer honouring `in_busy` → output sequence identical to input, `ovf_err = 0`, final `level = 0`.
- `level = 3`, assert `rst_n = 0` for one cycle while pushing → `level = 0`, `out_en = 0`, no stale word is delivered afterwards.
- With `HS_BUFFER_STATS_EN`: 10 pops plus 7 busy-with-data cycles → `stat_xfer = 10`, `stat_stall = 7`.
